// File: rtl/um245r_pkg.sv
// Shared types and default strobe timing for the UM245R host controller.
`default_nettype none

package um245r_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TX_SETUP = 3'd1,
    TX_HOLD  = 3'd2,
    RX_LOW   = 3'd3,
    RX_TAIL  = 3'd4,
    RECOVER  = 3'd5
  } state_t;

  localparam int DEF_WR_SETUP_CYC = 2;
  localparam int DEF_WR_HOLD_CYC  = 1;
  localparam int DEF_RD_DATA_CYC  = 3;
  localparam int DEF_RD_LOW_CYC   = 5;
  localparam int DEF_RECOVER_CYC  = 8;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/um245r_host_sync2.sv
// Two-flop synchroniser for the asynchronous FTDI status flags; resets to inactive (1).
`default_nettype none

module um245r_host_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/um245r_host.sv
// Host-side UM245R controller: byte valid/ready streams to WR/_RD strobes on the FTDI pins.
`default_nettype none

module um245r_host
  import um245r_pkg::*;
#(
  parameter int WR_SETUP_CYC = DEF_WR_SETUP_CYC,
  parameter int WR_HOLD_CYC  = DEF_WR_HOLD_CYC,
  parameter int RD_DATA_CYC  = DEF_RD_DATA_CYC,
  parameter int RD_LOW_CYC   = DEF_RD_LOW_CYC,
  parameter int RECOVER_CYC  = DEF_RECOVER_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  inout  wire  [7:0] D,
  output logic       WR,
  output logic       _RD,
  input  logic       _TXE,
  input  logic       _RXF
);

  localparam int MAX_CYC = max_of(max_of(max_of(WR_SETUP_CYC, WR_HOLD_CYC),
                                         max_of(RD_DATA_CYC, RD_LOW_CYC)), RECOVER_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             txe_s, rxf_s;
  logic             tx_full;
  logic [7:0]       tx_byte;
  logic             prefer_rx;
  logic             d_oe;
  logic             tx_ok, rx_ok, tx_accept;
  logic             start_tx, start_rx, sample_rx, set_rx_valid, tx_done;

  um245r_host_sync2 u_sync_txe (.clk(clk), .reset(reset), .async_in(_TXE), .sync_out(txe_s));
  um245r_host_sync2 u_sync_rxf (.clk(clk), .reset(reset), .async_in(_RXF), .sync_out(rxf_s));

  assign tx_ok     = tx_full && !txe_s;
  assign rx_ok     = !rxf_s && !rx_valid;
  assign tx_accept = tx_valid && tx_ready;
  assign D         = d_oe ? tx_byte : 'z;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    start_tx     = 1'b0;
    start_rx     = 1'b0;
    sample_rx    = 1'b0;
    set_rx_valid = 1'b0;
    tx_done      = 1'b0;
    if (state != IDLE && cnt != '0) begin
      cnt_nx = cnt - CNT_W'(1);
    end
    case (state)
      IDLE: begin
        // Both eligible: prefer_rx toggles on every start so the directions alternate.
        if (rx_ok && (!tx_ok || prefer_rx)) begin
          start_rx = 1'b1;
          state_nx = RX_LOW;
          cnt_nx   = CNT_W'(RD_DATA_CYC - 1);
        end else if (tx_ok) begin
          start_tx = 1'b1;
          state_nx = TX_SETUP;
          cnt_nx   = CNT_W'(WR_SETUP_CYC - 1);
        end
      end
      TX_SETUP: if (cnt == '0) begin
        state_nx = TX_HOLD;
        cnt_nx   = CNT_W'(WR_HOLD_CYC - 1);
      end
      TX_HOLD: if (cnt == '0) begin
        tx_done  = 1'b1;
        state_nx = RECOVER;
        cnt_nx   = CNT_W'(RECOVER_CYC - 1);
      end
      RX_LOW: if (cnt == '0) begin
        sample_rx = 1'b1;
        state_nx  = RX_TAIL;
        cnt_nx    = CNT_W'(RD_LOW_CYC - RD_DATA_CYC - 1);
      end
      RX_TAIL: if (cnt == '0) begin
        set_rx_valid = 1'b1;
        state_nx     = RECOVER;
        cnt_nx       = CNT_W'(RECOVER_CYC - 1);
      end
      RECOVER: if (cnt == '0) begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      tx_full   <= 1'b0;
      tx_byte   <= 8'h00;
      tx_ready  <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= 8'h00;
      prefer_rx <= 1'b1;
      WR        <= 1'b0;
      _RD       <= 1'b1;
      d_oe      <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;

      if (tx_done) begin
        tx_full <= 1'b0;
      end else if (tx_accept) begin
        tx_full <= 1'b1;
        tx_byte <= tx_data;
      end
      tx_ready <= tx_done || !(tx_full || tx_accept);

      if (start_rx) begin
        prefer_rx <= 1'b0;
      end else if (start_tx) begin
        prefer_rx <= 1'b1;
      end

      if (sample_rx) begin
        rx_data <= D;
      end
      if (set_rx_valid) begin
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      // Pins are registered from the next state so they change cleanly with it.
      WR   <= (state_nx == TX_SETUP);
      _RD  <= !((state_nx == RX_LOW) || (state_nx == RX_TAIL));
      d_oe <= (state_nx == TX_SETUP) || (state_nx == TX_HOLD);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_um245r_host.sv
// Bench: um245r_host against a small UM245R pin model with tx/rx scoreboards.
`default_nettype none

module tb_um245r_host;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  wire  [7:0] d_bus;
  logic       wr, rd_n;
  logic       txe_n = 1'b0;
  logic       rxf_n = 1'b1;

  logic [7:0] q_model[$];
  logic [7:0] model_byte = 8'h00;
  logic       rx_en = 1'b1;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  int  n_checks = 0;
  int  n_pass = 0;
  int  rd_falls = 0;
  int  strobe_idx = 0;
  logic log_dir = 1'b0;
  logic prev_wr = 1'b0;
  logic prev_rd = 1'b1;

  always #5 clk = ~clk;

  um245r_host dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .D(d_bus), .WR(wr), ._RD(rd_n), ._TXE(txe_n), ._RXF(rxf_n)
  );

  // FTDI side drives the bus while its read strobe is low.
  assign d_bus = !rd_n ? model_byte : 8'hzz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Pin model and scoreboard pops, sampled mid-cycle.
  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      if (prev_wr && !wr) begin
        if (tx_exp.size() == 0) check("tx_unexpected", 32'(d_bus), 32'hFFFF_FFFF);
        else check("tx_byte", 32'(d_bus), 32'(tx_exp.pop_front()));
      end
      if (rx_valid && rx_ready) begin
        if (rx_exp.size() == 0) check("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
        else check("rx_byte", 32'(rx_data), 32'(rx_exp.pop_front()));
      end
      if (!rd_n) begin
        check("d_driven_rd_low", 32'(dut.d_oe), 32'd0);
        check("wr_and_rd", 32'(wr), 32'd0);
      end
      if (log_dir && ((prev_rd && !rd_n) || (!prev_wr && wr))) begin
        check("arb_dir", 32'(!rd_n), 32'(strobe_idx % 2 == 0));
        strobe_idx++;
      end
    end
    if (prev_rd && !rd_n) rd_falls++;
    if (!prev_rd && rd_n && q_model.size() > 0) void'(q_model.pop_front());
    prev_wr    = wr;
    prev_rd    = rd_n;
    rxf_n      = !(rx_en && q_model.size() > 0);
    model_byte = (q_model.size() > 0) ? q_model[0] : 8'h00;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_tx(input logic [7:0] b);
    int t = 0;
    while (!tx_ready && t < 200) begin tick(); t++; end
    if (t >= 200) begin
      check("tx_ready_timeout", 32'(tx_ready), 32'd1);
      return;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    tx_exp.push_back(b);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic push_rx(input logic [7:0] b);
    q_model.push_back(b);
    rx_exp.push_back(b);
  endtask

  task automatic wait_rd_low(output int t);
    t = 0;
    while (rd_n && t < 100) begin tick(); t++; end
    if (t >= 100) check("rd_timeout", 32'(rd_n), 32'd0);
  endtask

  initial begin
    int t, n, f0;

    // 1: reset
    cycles(3);
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_rd", 32'(rd_n), 32'd1);
    check("rst_d_oe", 32'(dut.d_oe), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    reset = 1'b0;
    tick();
    check("tx_ready_after_rst", 32'(tx_ready), 32'd1);

    // 2: single write
    send_tx(8'h21);
    t = 0;
    while (!wr && t < 20) begin tick(); t++; end
    check("t2_wr_rise_lat", 32'(t), 32'd1);
    for (int i = 0; i < 2; i++) begin
      check("t2_setup_wr", 32'(wr), 32'd1);
      check("t2_setup_d", 32'(d_bus), 32'h21);
      tick();
    end
    check("t2_wr_fell", 32'(wr), 32'd0);
    check("t2_hold_oe", 32'(dut.d_oe), 32'd1);
    check("t2_hold_d", 32'(d_bus), 32'h21);
    tick();
    check("t2_release_oe", 32'(dut.d_oe), 32'd0);
    check("t2_tx_ready", 32'(tx_ready), 32'd1);
    cycles(10);

    // 3: write blocked by _TXE
    txe_n = 1'b1;
    cycles(5);
    send_tx(8'h41);
    check("t3_tx_ready_low", 32'(tx_ready), 32'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (wr) n++; end
    check("t3_no_wr", 32'(n), 32'd0);
    txe_n = 1'b0;
    t = 0;
    while (!wr && t < 20) begin tick(); t++; end
    check("t3_wr_lat", 32'(t), 32'd3);
    cycles(15);

    // 4: single read, held until accepted
    push_rx(8'h5A);
    wait_rd_low(t);
    n = 0;
    while (!rd_n && n < 20) begin tick(); n++; end
    check("t4_rd_low_cycles", 32'(n), 32'd5);
    check("t4_rx_valid", 32'(rx_valid), 32'd1);
    cycles(10);
    check("t4_rx_hold", 32'(rx_valid), 32'd1);
    check("t4_rx_data_hold", 32'(rx_data), 32'h5A);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("t4_rx_cleared", 32'(rx_valid), 32'd0);
    cycles(12);

    // 5: backpressure
    f0 = rd_falls;
    push_rx(8'h01);
    push_rx(8'h02);
    cycles(40);
    check("t5_one_pulse", 32'(rd_falls - f0), 32'd1);
    rx_ready = 1'b1;
    cycles(40);
    check("t5_two_pulses", 32'(rd_falls - f0), 32'd2);

    // 6: interleaved streams, RX first after reset
    reset = 1'b1;
    txe_n = 1'b1;
    rx_en = 1'b0;
    cycles(3);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) push_rx(8'(8'h80 + i));
    send_tx(8'h30);
    cycles(4);
    strobe_idx = 0;
    log_dir = 1'b1;
    txe_n = 1'b0;
    rx_en = 1'b1;
    for (int i = 1; i < 16; i++) send_tx(8'(8'h30 + i));
    t = 0;
    while ((tx_exp.size() != 0 || rx_exp.size() != 0) && t < 2000) begin tick(); t++; end
    cycles(12);
    log_dir = 1'b0;
    check("t6_strobes", 32'(strobe_idx), 32'd32);
    check("t6_tx_drained", 32'(tx_exp.size()), 32'd0);
    check("t6_rx_drained", 32'(rx_exp.size()), 32'd0);

    // reset during RX_LOW drops the byte
    push_rx(8'h99);
    wait_rd_low(t);
    reset = 1'b1;
    tick();
    check("rst_rx_rd", 32'(rd_n), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    rx_exp.delete();
    q_model.delete();
    reset = 1'b0;
    cycles(20);
    check("end_rx_idle", 32'(rx_valid), 32'd0);
    check("end_tx_empty", 32'(tx_exp.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
